div_ctrl: RTL

- Issue/sequencing stage between the execute stage and the iterative divider `div`.
- Accepts a DIV/DIVU/REM/REMU request from execute and stalls the pipeline while the divider runs.
- Launches the divider with a one-cycle enable at the divider's idle count, captures its one-cycle ready pulse, and returns a registered result.
- Handles pipeline flush mid-operation by draining the divider, and keeps a one-entry result cache so that a replayed identical request completes without re-dividing.

---
 rtl/div_ctrl_pkg.sv | 58 +++++
 rtl/div.sv | 91 +++++++++
 rtl/div_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared types for the divider issue stage and the iterative divider
package div_ctrl_pkg;

    typedef struct packed {
        logic divs;
        logic divu;
        logic rem;
        logic remu;
    } div_op_type;

    typedef struct packed {
        logic        enable;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        div_op_type  div_op;
    } div_in_type;

    typedef struct packed {
        logic        ready;
        logic [31:0] result;
    } div_out_type;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN,
        DONE
    } div_ctrl_state_type;

    localparam int KEY_W = 4 + 32 + 32;

    typedef struct packed {
        div_ctrl_state_type state;
        logic [KEY_W-1:0]   key;
        logic [31:0]        cache_result;
        logic               cache_valid;
        logic [31:0]        result;
    } div_ctrl_reg_type;

    localparam div_ctrl_reg_type init_div_ctrl_reg = '{
        state:        IDLE,
        key:          '0,
        cache_result: '0,
        cache_valid:  1'b0,
        result:       '0
    };

    // Number of significant bits; drives the leading-zero skip of the divider.
    function automatic logic [5:0] sig_bits(input logic [31:0] x);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) n = 6'(i + 1);
        end
        return n;
    endfunction

endpackage

// File: rtl/div.sv
// rtl/div.sv - iterative restoring divider, one bit per cycle over the significant dividend bits
module div
    import div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  div_in_type  div_in,
    output div_out_type div_out
);

    logic        busy;
    logic [5:0]  cnt;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem_q;
    logic [31:0] orig;
    logic        neg_q;
    logic        neg_r;
    logic        is_rem;
    logic        by_zero;

    logic        sgn;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [5:0]  n_bits;
    logic [32:0] rem_shift;

    always_comb begin
        sgn       = div_in.div_op.divs | div_in.div_op.rem;
        abs_a     = (sgn && div_in.rdata1[31]) ? -div_in.rdata1 : div_in.rdata1;
        abs_b     = (sgn && div_in.rdata2[31]) ? -div_in.rdata2 : div_in.rdata2;
        n_bits    = (div_in.rdata2 == '0) ? 6'd0 : sig_bits(abs_a);
        rem_shift = {rem_q, dvd[31]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            quo     <= '0;
            rem_q   <= '0;
            orig    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            is_rem  <= 1'b0;
            by_zero <= 1'b0;
        end else if (!busy) begin
            if (div_in.enable && (div_in.div_op != '0)) begin
                busy    <= 1'b1;
                cnt     <= n_bits;
                // Left-align the dividend so the first step consumes its top set bit.
                dvd     <= abs_a << (6'd32 - n_bits);
                dvs     <= abs_b;
                quo     <= '0;
                rem_q   <= '0;
                orig    <= div_in.rdata1;
                neg_q   <= sgn & (div_in.rdata1[31] ^ div_in.rdata2[31]);
                neg_r   <= sgn & div_in.rdata1[31];
                is_rem  <= div_in.div_op.rem | div_in.div_op.remu;
                by_zero <= (div_in.rdata2 == '0);
            end
        end else if (cnt != '0) begin
            if (rem_shift >= {1'b0, dvs}) begin
                rem_q <= 32'(rem_shift - {1'b0, dvs});
                quo   <= {quo[30:0], 1'b1};
            end else begin
                rem_q <= rem_shift[31:0];
                quo   <= {quo[30:0], 1'b0};
            end
            dvd <= dvd << 1;
            cnt <= cnt - 6'd1;
        end else begin
            busy <= 1'b0;
        end
    end

    always_comb begin
        div_out.ready = busy && (cnt == '0);
        if (by_zero) begin
            div_out.result = is_rem ? orig : 32'hFFFF_FFFF;
        end else if (is_rem) begin
            div_out.result = neg_r ? -rem_q : rem_q;
        end else begin
            div_out.result = neg_q ? -quo : quo;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - divider issue stage: stall, flush drain and one-entry result cache
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  div_op_type  req_op,
    input  logic [31:0] req_rdata1,
    input  logic [31:0] req_rdata2,
    input  logic        flush,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_result,
    output div_in_type  div_in,
    input  div_out_type div_out
);

    div_ctrl_reg_type r;
    div_ctrl_reg_type rin;
    div_ctrl_reg_type v;
    logic [KEY_W-1:0] req_key;
    logic             hit;

    always_comb begin
        v           = r;
        stall       = 1'b0;
        resp_valid  = 1'b0;
        resp_result = '0;
        div_in      = '0;
        req_key     = {req_op, req_rdata1, req_rdata2};
        hit         = CACHE_EN && r.cache_valid && (r.key == req_key);

        case (r.state)
            IDLE: begin
                if (!flush && req_valid) begin
                    if (req_op == '0) begin
                        resp_valid = 1'b1;
                    end else if (hit) begin
                        resp_valid  = 1'b1;
                        resp_result = r.cache_result;
                    end else begin
                        div_in.enable = 1'b1;
                        div_in.rdata1 = req_rdata1;
                        div_in.rdata2 = req_rdata2;
                        div_in.div_op = req_op;
                        stall         = 1'b1;
                        // The key now names the in-flight op; it is valid again only once its result lands.
                        v.key         = req_key;
                        v.cache_valid = 1'b0;
                        v.state       = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (div_out.ready) begin
                    v.result       = div_out.result;
                    v.cache_result = div_out.result;
                    v.cache_valid  = CACHE_EN;
                    v.state        = flush ? IDLE : DONE;
                end else if (flush) begin
                    v.state = DRAIN;
                end
            end
            DRAIN: begin
                stall = req_valid;
                if (div_out.ready) begin
                    v.cache_result = div_out.result;
                    v.cache_valid  = CACHE_EN;
                    v.state        = IDLE;
                end
            end
            DONE: begin
                resp_valid  = !flush;
                resp_result = flush ? 32'h0 : r.result;
                v.state     = IDLE;
            end
            default: v.state = IDLE;
        endcase

        if (!rst) begin
            v           = init_div_ctrl_reg;
            stall       = 1'b0;
            resp_valid  = 1'b0;
            resp_result = '0;
            div_in      = '0;
        end
        rin = v;
    end

    always_ff @(posedge clk) begin
        r <= rin;
    end

endmodule
